// File: rtl/uart_fifo_unit.sv
// uart_fifo_unit -- full-duplex UART with independent RX and TX byte FIFOs.
//
// The frame is 8N1 by default. Defining UART_PARITY_EN selects 8E1: an
// even-parity bit follows the data bits, and the parity_err_o port is added.
//
// Ports
//   clk_i, rst_i           clock; synchronous active-high reset
//   tx_data_i/tx_valid_i   byte stream into the TX FIFO; tx_ready_o = FIFO not full
//   rx_data_o/rx_valid_o   show-ahead head of the RX FIFO; rx_ready_i pops it
//   tx_count_o/rx_count_o  FIFO occupancy, 0..DEPTH
//   err_clr_i              clears the sticky error flags
//   overrun_o, frame_err_o sticky error flags (parity_err_o with UART_PARITY_EN)
//   txd_o                  serial out, idle high
//   rxd_i                  serial in, asynchronous
//
// uart_fifo_buf is the circular byte buffer that both directions use.

module uart_fifo_buf #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A full buffer still takes a push when the same edge frees a slot.
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push != do_pop) count_q <= do_push ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
endmodule

module uart_fifo_unit #(
    parameter int  CLK_PER_HALF_BIT = 434,
    parameter int  DEPTH            = 16,
    localparam int CW               = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [7:0]    tx_data_i,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    output logic [7:0]    rx_data_o,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output logic [CW-1:0] tx_count_o,
    output logic [CW-1:0] rx_count_o,
    input  logic          err_clr_i,
    output logic          overrun_o,
    output logic          frame_err_o,
`ifdef UART_PARITY_EN
    output logic          parity_err_o,
`endif
    output logic          txd_o,
    input  logic          rxd_i
);
    localparam int                BIT       = 2 * CLK_PER_HALF_BIT;
    localparam int                CNT_W     = $clog2(BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    // ---------------- TX ----------------
    state_e           tx_st_q, tx_st_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d, tx_head;
    logic             txd_q, txd_d, tx_tick, tx_load, tx_full, tx_empty;
`ifdef UART_PARITY_EN
    logic             tx_par_q, tx_par_d;
`endif

    assign tx_ready_o = ~tx_full;
    assign tx_tick    = (tx_cnt_q == BIT_LAST);
    assign txd_o      = txd_q;

    uart_fifo_buf #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(tx_valid_i & ~tx_full), .wdata_i(tx_data_i),
        .pop_i(tx_load), .rdata_o(tx_head), .count_o(tx_count_o), .full_o(tx_full), .empty_o(tx_empty)
    );

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_load  = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d = tx_par_q;
`endif
        case (tx_st_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                tx_load  = ~tx_empty;
            end
            S_START: if (tx_tick) begin
                tx_st_d  = S_DATA;
                tx_bit_d = '0;
            end
            S_DATA: if (tx_tick) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 1'b1;
`ifdef UART_PARITY_EN
                if (tx_bit_q == 3'd7) tx_st_d = S_PARITY;
`else
                if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (tx_tick) tx_st_d = S_STOP;
`endif
            // Leaving STOP with data queued goes straight to START: no idle gap.
            S_STOP: if (tx_tick) begin
                tx_st_d = S_IDLE;
                tx_load = ~tx_empty;
            end
            default: tx_st_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_st_d  = S_START;
            tx_cnt_d = '0;
            tx_sh_d  = tx_head;
`ifdef UART_PARITY_EN
            tx_par_d = ^tx_head;
`endif
        end
    end

    // txd is registered from the current state, so it lags the state by one cycle.
    always_comb begin
        txd_d = 1'b1;
        case (tx_st_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = tx_sh_q[0];
`ifdef UART_PARITY_EN
            S_PARITY: txd_d = tx_par_q;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    state_e           rx_st_q, rx_st_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d, rx_head;
    logic             rx_s1_q, rx_s2_q, rx_prev_q, rx_tick, rx_push, rx_full, rx_empty;
    logic             ovr_set, fe_set, ovr_q, fe_q;
`ifdef UART_PARITY_EN
    logic             rx_pbad_q, rx_pbad_d, pe_set, pe_q;
    assign parity_err_o = pe_q;
`endif

    assign rx_tick     = (rx_cnt_q == BIT_LAST);
    assign rx_valid_o  = ~rx_empty;
    assign rx_data_o   = rx_empty ? 8'h00 : rx_head;
    assign ovr_set     = rx_push & rx_full & ~(rx_ready_i & ~rx_empty);
    assign overrun_o   = ovr_q;
    assign frame_err_o = fe_q;

    uart_fifo_buf #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push), .wdata_i(rx_sh_q),
        .pop_i(rx_ready_i), .rdata_o(rx_head), .count_o(rx_count_o), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        fe_set   = 1'b0;
`ifdef UART_PARITY_EN
        rx_pbad_d = rx_pbad_q;
        pe_set    = 1'b0;
`endif
        case (rx_st_q)
            // Requiring prev=1 also covers re-arming after a bad stop bit:
            // a line held low never shows a falling edge.
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q & ~rx_s2_q) rx_st_d = S_START;
            end
            S_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;   // high at mid-start: glitch
            end
            S_DATA: if (rx_tick) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
`ifdef UART_PARITY_EN
                if (rx_bit_q == 3'd7) rx_st_d = S_PARITY;
`else
                if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (rx_tick) begin
                rx_cnt_d  = '0;
                rx_pbad_d = rx_s2_q ^ (^rx_sh_q);
                rx_st_d   = S_STOP;
            end
`endif
            S_STOP: if (rx_tick) begin
                rx_cnt_d = '0;
                rx_st_d  = S_IDLE;
                rx_push  = rx_s2_q;
                fe_set   = ~rx_s2_q;
`ifdef UART_PARITY_EN
                pe_set   = rx_pbad_q;
`endif
            end
            default: rx_st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_st_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            txd_q     <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q  <= 1'b0;
            rx_pbad_q <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            txd_q     <= txd_d;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_s1_q   <= rxd_i;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            // Set wins over a simultaneous clear.
            ovr_q     <= ovr_set | (ovr_q & ~err_clr_i);
            fe_q      <= fe_set  | (fe_q  & ~err_clr_i);
`ifdef UART_PARITY_EN
            tx_par_q  <= tx_par_d;
            rx_pbad_q <= rx_pbad_d;
            pe_q      <= pe_set  | (pe_q  & ~err_clr_i);
`endif
        end
    end
endmodule

// File: tb/tb_uart_fifo_unit.sv
`timescale 1ns/1ps
module tb_uart_fifo_unit;
    localparam int H = 4, DEPTH = 4, CW = 3, BIT = 2 * H;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    // Edges from the first edge that sees rxd low to the stop-sample edge:
    // two synchronizer stages, half a bit to mid-start, then one bit per
    // remaining frame bit.
    localparam int RX_LAT = 2 + H + (FB - 1) * BIT;

    logic          clk, rst, tx_valid, tx_ready, rx_valid, rx_ready, err_clr;
    logic          overrun, frame_err, txd, rxd, rxd_drv, loop;
    logic [7:0]    tx_data, rx_data;
    logic [CW-1:0] tx_count, rx_count;
`ifdef UART_PARITY_EN
    logic          parity_err;
`endif

    assign rxd = loop ? txd : rxd_drv;

    uart_fifo_unit #(.CLK_PER_HALF_BIT(H), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .tx_count_o(tx_count), .rx_count_o(rx_count), .err_clr_i(err_clr),
        .overrun_o(overrun), .frame_err_o(frame_err),
`ifdef UART_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .txd_o(txd), .rxd_i(rxd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int at; logic [7:0] b; bit stop; bit par_ok; } rxev_t;
    logic [7:0] mtxq[$], mrxq[$];
    rxev_t      pend[$];
    int         m_free_at = 0, m_fs = 0;
    logic [7:0] m_fbyte = 8'h00;
    bit         m_fact = 0, m_ovr = 0, m_fe = 0, m_pe = 0, m_acc = 0, m_init = 0;

    always @(posedge clk) begin
        int    ntx, nrx;
        bit    rxpop, ovr_s, fe_s, pe_s;
        rxev_t e;
        cyc++;
        m_acc = 0;
        if (rst) begin
            mtxq.delete(); mrxq.delete(); pend.delete();
            m_free_at = 0; m_fact = 0; m_ovr = 0; m_fe = 0; m_pe = 0; m_init = 1;
        end else begin
            ntx = mtxq.size();
            nrx = mrxq.size();
            ovr_s = 0; fe_s = 0; pe_s = 0;
            // transmitter takes the next byte once the previous frame has fully elapsed
            if (ntx > 0 && cyc >= m_free_at) begin
                m_fbyte = mtxq.pop_front();
                m_fs = cyc + 1;
                m_fact = 1;
                m_free_at = cyc + FB * BIT;
                if (loop) pend.push_back('{m_fs + 1 + RX_LAT, m_fbyte, 1'b1, 1'b1});
            end
            if (tx_valid && ntx < DEPTH) begin
                mtxq.push_back(tx_data);
                m_acc = 1;
            end
            rxpop = rx_ready && nrx > 0;
            if (rxpop) void'(mrxq.pop_front());
            if (pend.size() > 0 && pend[0].at == cyc) begin
                e = pend.pop_front();
                if (!e.par_ok) pe_s = 1;
                if (!e.stop) fe_s = 1;
                else if (nrx < DEPTH || rxpop) mrxq.push_back(e.b);
                else ovr_s = 1;
            end
            m_ovr = ovr_s || (m_ovr && !err_clr);
            m_fe  = fe_s  || (m_fe  && !err_clr);
            m_pe  = pe_s  || (m_pe  && !err_clr);
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_fact || cyc < m_fs || cyc >= m_fs + FB * BIT) return 1'b1;
        k = (cyc - m_fs) / BIT;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_fbyte[k-1];
        if (k == 9 && FB == 11) return ^m_fbyte;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (m_init) begin
            check("txd", txd, exp_txd());
            check("tx_ready", tx_ready, mtxq.size() < DEPTH);
            check("tx_count", tx_count, mtxq.size());
            check("rx_valid", rx_valid, mrxq.size() > 0);
            if (mrxq.size() > 0) check("rx_data", rx_data, mrxq[0]);
            check("rx_count", rx_count, mrxq.size());
            check("overrun", overrun, m_ovr);
            check("frame_err", frame_err, m_fe);
`ifdef UART_PARITY_EN
            check("parity_err", parity_err, m_pe);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_tx(input logic [7:0] b);
        int w;
        tx_data = b;
        tx_valid = 1'b1;
        w = 0;
        do begin tick(); w++; end while (!m_acc && w < 1000);
        check("push_accept_timeout", m_acc, 1);
        tx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_ok);
        logic [FB-1:0] f;
        pend.push_back('{cyc + 1 + RX_LAT, b, stop, par_ok});
        f = '0;
        f[8:1] = b;
`ifdef UART_PARITY_EN
        f[9] = (^b) ^ ~par_ok;
`endif
        f[FB-1] = stop;
        for (int i = 0; i < FB; i++) begin
            rxd_drv = f[i];
            tick(BIT);
        end
        rxd_drv = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [0:7] seq;
        rst = 1; tx_valid = 0; tx_data = 0; rx_ready = 0; err_clr = 0; rxd_drv = 1; loop = 0;
        tick();
        rst = 0;
        check("rst_txd", txd, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_counts", {tx_count, rx_count}, 0);
        check("rst_flags", {overrun, frame_err}, 0);
        tick(3);

        // 1: single byte A5, LSB first
        push_tx(8'hA5);
        check("t1_count_after_push", tx_count, 1);
        tick();
        check("t1_count_after_pop", tx_count, 0);
        check("t1_txd_still_idle", txd, 1);
        tick();
        check("t1_start_bit", txd, 0);
        tick(4);
        seq = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            tick(BIT);
            check("t1_data_bit", txd, seq[i]);
        end
        tick(BIT);
        check("t1_stop_bit", txd, 1);
        tick(FB * BIT);

        // 2: fill the TX FIFO behind the frame already in the shifter
        for (int i = 1; i <= 5; i++) push_tx(8'(i));
        check("t2_full_ready", tx_ready, 0);
        check("t2_peak_count", tx_count, 4);
        tx_data = 8'h06; tx_valid = 1;
        tick();
        tx_valid = 0;
        check("t2_ignored_push", tx_count, 4);
        tick(5 * FB * BIT + 20);

        // 3: loopback of 3C
        loop = 1;
        push_tx(8'h3C);
        tick(2 + RX_LAT);
        check("t3_not_yet_valid", rx_valid, 0);
        tick();
        check("t3_valid", rx_valid, 1);
        check("t3_data", rx_data, 8'h3C);
        rx_ready = 1; tick(); rx_ready = 0;
        check("t3_popped", {rx_valid, rx_count}, 0);
        tick(10);
        loop = 0;
        tick(5);

        // 4: overrun on five unread frames
        send_frame(8'h11, 1, 1);
        send_frame(8'h22, 1, 1);
        send_frame(8'h33, 1, 1);
        send_frame(8'h44, 1, 1);
        send_frame(8'h55, 1, 1);
        check("t4_count", rx_count, 4);
        check("t4_overrun", overrun, 1);
        check("t4_head", rx_data, 8'h11);
        err_clr = 1; tick(); err_clr = 0;
        check("t4_cleared", overrun, 0);
        // push into a full FIFO on the same edge as a pop: no overrun
        fork
            send_frame(8'h66, 1, 1);
            begin
                tick(RX_LAT);
                rx_ready = 1; tick(); rx_ready = 0;
            end
        join
        check("t4_pushpop_count", rx_count, 4);
        check("t4_pushpop_no_ovr", overrun, 0);
        check("t4_pushpop_head", rx_data, 8'h22);
        rx_ready = 1; tick(4); rx_ready = 0;
        check("t4_drained", rx_count, 0);

        // 5: framing error, then a short glitch
        send_frame(8'h55, 0, 1);
        check("t5_frame_err", frame_err, 1);
        check("t5_count", rx_count, 0);
        err_clr = 1; tick(); err_clr = 0;
        check("t5_cleared", frame_err, 0);
        rxd_drv = 0; tick(2); rxd_drv = 1;
        tick(4 * BIT);
        check("t5_glitch", {rx_valid, frame_err}, 0);

        // 6: reset in the middle of data bit 3 (bit 3 of F0 is 0)
        push_tx(8'hF0);
        push_tx(8'h12);
        push_tx(8'h34);
        tick(2 + 4 * BIT);
        check("t6_pre_rst_txd", txd, 0);
        rst = 1; tick(); rst = 0;
        check("t6_txd", txd, 1);
        check("t6_counts", {tx_count, rx_count}, 0);
        tick(20);
        check("t6_idle_after_rst", txd, 1);

`ifdef UART_PARITY_EN
        loop = 1;
        push_tx(8'h07);
        tick(1 + 9 * BIT + 4);
        check("t6p_parity_bit", txd, 1);
        tick(20);
        check("t6p_rx_data", rx_data, 8'h07);
        check("t6p_no_perr", parity_err, 0);
        loop = 0;
        tick(4);
        send_frame(8'h5A, 1, 0);
        check("t6p_bad_parity", parity_err, 1);
        check("t6p_still_pushed", rx_count, 2);
`endif
        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
